// File: rtl/cache_ctrl.sv
// Lookup/control FSM for a direct-mapped write-back cache: hit/miss decision,
// writeback and line-fill sequencing, metadata strobes and hit/miss statistics.
//
// state  | meaning
// IDLE   | waiting for cpu_req; latches address and direction on accept
// LOOKUP | compares the selected line against the latched tag
// WB     | writing the dirty victim line back to memory
// FILL   | fetching the requested line from memory
// ALLOC  | loads the new tag / sets valid (and dirty on a write)
// RESP   | one-cycle cpu_ready with the lookup result
module cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 19,
    parameter int IDX_W  = 8,
    parameter int OFF_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              busy,
    output logic [IDX_W-1:0]  line_sel,
    output logic              line_en,
    output logic              line_change,
    output logic              line_alloc,
    output logic [TAG_W-1:0]  line_tag,
    input  logic              line_valid,
    input  logic              line_dirty,
    input  logic [TAG_W-1:0]  line_tag_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_ALLOC,
        S_RESP
    } state_t;

    state_t             state, next_state;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic               req_we;
    logic [TAG_W-1:0]   victim_tag;
    logic               hit_q;
    logic               mem_req_q;
    logic [CNT_W-1:0]   hit_cnt_q;
    logic [CNT_W-1:0]   miss_cnt_q;
    logic               lookup_hit;
    logic               unused_off;

    // Byte offset is irrelevant to a line-granular controller.
    assign unused_off = ^cpu_addr[OFF_W-1:0];

    assign lookup_hit = line_valid && (line_tag_in == req_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_tag    <= '0;
            req_idx    <= '0;
            req_we     <= 1'b0;
            victim_tag <= '0;
            hit_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state     <= next_state;
            mem_req_q <= (next_state == S_WB) || (next_state == S_FILL);
            if (state == S_IDLE && cpu_req) begin
                req_tag <= cpu_addr[ADDR_W-1 -: TAG_W];
                req_idx <= cpu_addr[OFF_W +: IDX_W];
                req_we  <= cpu_we;
            end
            if (state == S_LOOKUP) begin
                hit_q <= lookup_hit;
                if (lookup_hit) begin
                    if (hit_cnt_q != '1)
                        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                end else begin
                    if (miss_cnt_q != '1)
                        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                    victim_tag <= line_tag_in;
                end
            end
        end
    end

    always_comb begin
        next_state  = state;
        line_en     = 1'b0;
        line_change = 1'b0;
        line_alloc  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        cpu_ready   = 1'b0;
        cpu_hit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req)
                    next_state = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    next_state  = S_RESP;
                    line_en     = req_we;
                    line_change = req_we;
                end else if (line_valid && line_dirty) begin
                    next_state = S_WB;
                end else begin
                    next_state = S_FILL;
                end
            end
            S_WB: begin
                mem_we   = 1'b1;
                mem_addr = {victim_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_ack)
                    next_state = S_FILL;
            end
            S_FILL: begin
                mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_ack)
                    next_state = S_ALLOC;
            end
            S_ALLOC: begin
                line_en     = 1'b1;
                line_alloc  = 1'b1;
                line_change = req_we;
                next_state  = S_RESP;
            end
            S_RESP: begin
                cpu_ready  = 1'b1;
                cpu_hit    = hit_q;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign mem_req  = mem_req_q;
    assign line_sel = req_idx;
    assign line_tag = req_tag;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a behavioural metadata array and memory
// responder around the controller, plus a narrow-counter copy for saturation.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        mem_ack = 1'b0;

    logic        cpu_ready, cpu_hit, busy;
    logic [7:0]  line_sel;
    logic        line_en, line_change, line_alloc;
    logic [18:0] line_tag;
    logic        line_valid, line_dirty;
    logic [18:0] line_tag_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [15:0] hit_cnt, miss_cnt;

    logic        unused_rdy, unused_hit, unused_busy, unused_en, unused_chg, unused_alc;
    logic        unused_mreq, unused_mwe;
    logic [7:0]  unused_sel;
    logic [18:0] unused_tag;
    logic [31:0] unused_maddr;
    logic [2:0]  sat_hit_cnt, sat_miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .busy(busy), .line_sel(line_sel),
        .line_en(line_en), .line_change(line_change), .line_alloc(line_alloc),
        .line_tag(line_tag), .line_valid(line_valid), .line_dirty(line_dirty),
        .line_tag_in(line_tag_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_ctrl #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ready(unused_rdy), .cpu_hit(unused_hit), .busy(unused_busy), .line_sel(unused_sel),
        .line_en(unused_en), .line_change(unused_chg), .line_alloc(unused_alc),
        .line_tag(unused_tag), .line_valid(line_valid), .line_dirty(line_dirty),
        .line_tag_in(line_tag_in), .mem_req(unused_mreq), .mem_we(unused_mwe),
        .mem_addr(unused_maddr), .mem_ack(mem_ack), .hit_cnt(sat_hit_cnt), .miss_cnt(sat_miss_cnt)
    );

    // Metadata array model: combinational read, strobe-driven update.
    logic        m_valid [256];
    logic        m_dirty [256];
    logic [18:0] m_tag   [256];

    assign line_valid  = m_valid[line_sel];
    assign line_dirty  = m_dirty[line_sel];
    assign line_tag_in = m_tag[line_sel];

    always @(posedge clk) begin
        if (line_en) begin
            if (line_alloc) begin
                m_valid[line_sel] <= 1'b1;
                m_tag[line_sel]   <= line_tag;
            end
            if (line_change)
                m_dirty[line_sel] <= 1'b1;
        end
    end

    int checks = 0;
    int failures = 0;

    int          lat;
    logic        rsp_hit;
    int          n_wb, n_fill, n_alloc, n_change;
    logic [31:0] wb_addr, fill_addr;
    logic [18:0] alloc_tag;
    logic [7:0]  alloc_sel;
    logic        alloc_change;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; memory acks after wb_d / fill_d cycles of mem_req.
    task automatic do_req(input logic we, input logic [31:0] addr, input int wb_d, input int fill_d);
        int  cnt;
        bit  done;
        cnt = 0;
        done = 0;
        lat = 0; rsp_hit = 1'bx;
        n_wb = 0; n_fill = 0; n_alloc = 0; n_change = 0;
        wb_addr = '0; fill_addr = '0; alloc_tag = '0; alloc_sel = '0; alloc_change = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
        for (int k = 1; k <= 80 && !done; k++) begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end
            if (mem_req) begin
                cnt++;
                if (cnt == (mem_we ? wb_d : fill_d)) begin
                    if (mem_we) begin n_wb++; wb_addr = mem_addr; end
                    else begin n_fill++; fill_addr = mem_addr; end
                    mem_ack = 1'b1;
                end
            end
            if (line_en) begin
                if (line_alloc) begin
                    n_alloc++;
                    alloc_tag = line_tag;
                    alloc_sel = line_sel;
                    alloc_change = line_change;
                end else if (line_change) begin
                    n_change++;
                end
            end
            if (cpu_ready) begin
                lat = k;
                rsp_hit = cpu_hit;
                done = 1;
                cpu_req = 1'b0;
            end
        end
        if (!done) begin
            cpu_req = 1'b0;
            chk("req_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Cold read miss
        do_req(1'b0, 32'h0000_1240, 1, 3);
        chk("t1_lat", lat, 32'd6);
        chk("t1_hit", {31'd0, rsp_hit}, 32'd0);
        chk("t1_nwb", n_wb, 32'd0);
        chk("t1_fill_addr", fill_addr, 32'h0000_1240);
        chk("t1_alloc_sel", {24'd0, alloc_sel}, 32'h92);
        chk("t1_alloc_tag", {13'd0, alloc_tag}, 32'd0);
        chk("t1_alloc_chg", {31'd0, alloc_change}, 32'd0);
        chk("t1_miss_cnt", {16'd0, miss_cnt}, 32'd1);

        // Repeat read hits
        do_req(1'b0, 32'h0000_1240, 1, 1);
        chk("t2_lat", lat, 32'd2);
        chk("t2_hit", {31'd0, rsp_hit}, 32'd1);
        chk("t2_nfill", n_fill, 32'd0);
        chk("t2_hit_cnt", {16'd0, hit_cnt}, 32'd1);

        // Write hit sets dirty in LOOKUP
        do_req(1'b1, 32'h0000_1250, 1, 1);
        chk("t3_lat", lat, 32'd2);
        chk("t3_hit", {31'd0, rsp_hit}, 32'd1);
        chk("t3_change", n_change, 32'd1);
        chk("t3_alloc", n_alloc, 32'd0);
        chk("t3_dirty", {31'd0, m_dirty[8'h92]}, 32'd1);

        // Dirty conflict: victim tag 2 at index 0x92
        m_valid[8'h92] = 1'b1;
        m_dirty[8'h92] = 1'b1;
        m_tag[8'h92]   = 19'h00002;
        do_req(1'b0, 32'h0000_3240, 2, 1);
        chk("t4_lat", lat, 32'd6);
        chk("t4_nwb", n_wb, 32'd1);
        chk("t4_wb_addr", wb_addr, 32'h0000_5240);
        chk("t4_fill_addr", fill_addr, 32'h0000_3240);
        chk("t4_alloc_tag", {13'd0, alloc_tag}, 32'd1);
        chk("t4_alloc_chg", {31'd0, alloc_change}, 32'd0);
        chk("t4_cnts", {hit_cnt, miss_cnt}, {16'd2, 16'd2});

        // Stray mem_ack in IDLE
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("ack_idle_busy", {31'd0, busy}, 32'd0);
        chk("ack_idle_req", {31'd0, mem_req}, 32'd0);

        // Reset during FILL
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0400;
        @(negedge clk);
        @(negedge clk);
        chk("t5_mem_req_pre", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ready", {31'd0, cpu_ready}, 32'd0);
        chk("t5_cnts", {hit_cnt, miss_cnt}, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(1'b0, 32'h0000_3240, 1, 1);
        chk("t5_post_lat", lat, 32'd2);
        chk("t5_post_hit", {31'd0, rsp_hit}, 32'd1);
        chk("t5_post_hcnt", {16'd0, hit_cnt}, 32'd1);

        // Write miss allocates dirty
        do_req(1'b1, 32'h0000_0400, 1, 2);
        chk("wm_lat", lat, 32'd5);
        chk("wm_alloc_chg", {31'd0, alloc_change}, 32'd1);
        chk("wm_alloc_sel", {24'd0, alloc_sel}, 32'h20);
        chk("wm_miss_cnt", {16'd0, miss_cnt}, 32'd1);

        // Counter saturation on the 3-bit copy
        for (int i = 0; i < 6; i++)
            do_req(1'b0, 32'h0000_3240, 1, 1);
        chk("sat_hit_7", {29'd0, sat_hit_cnt}, 32'd7);
        chk("sat_main_7", {16'd0, hit_cnt}, 32'd7);
        do_req(1'b0, 32'h0000_3240, 1, 1);
        chk("sat_hit_hold", {29'd0, sat_hit_cnt}, 32'd7);
        chk("sat_main_8", {16'd0, hit_cnt}, 32'd8);
        chk("sat_miss", {29'd0, sat_miss_cnt}, 32'd1);
        chk("sat_main_miss", {16'd0, miss_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
